// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state, reset PC and a
// per-stage stall/flush bundle.
package pipes;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctl_t;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Down-counter that tracks the remaining stall cycles of a multi-cycle
// execute op. A data-bus wait freezes it; an accepted redirect clears it.
module mc_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] lat,
    input  logic         freeze,
    input  logic         clear,
    output logic         busy
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         start_ok;

    assign start_ok = start & (lat > W'(1));
    // The start cycle itself is one stall cycle, so lat-2 more follow.
    assign busy     = (cnt_q != '0) | start_ok;

    always_comb begin
        cnt_d = cnt_q;
        if (freeze)              cnt_d = cnt_q;
        else if (clear)          cnt_d = '0;
        else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
        else if (start_ok)       cnt_d = lat - W'(2);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Prioritised stall/flush decision for the F/D/E/M/W pipeline plus the
// fetch PC and a buffered redirect target for redirects seen mid-fetch.
module pipe_ctrl
    import pipes::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MC_LAT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ifetch_ok,
    input  logic                dmem_req,
    input  logic                dmem_ok,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic [4:0]          ex_ra1,
    input  logic [4:0]          ex_ra2,
    input  logic                ex_uses_rs2,
    input  logic                mem_is_load,
    input  logic [4:0]          mem_dst,
    input  logic                mc_start,
    input  logic [MC_LAT_W-1:0] mc_lat,
    output logic [XLEN-1:0]     pc_o,
    output logic                stall_f,
    output logic                stall_d,
    output logic                stall_e,
    output logic                stall_m,
    output logic                flush_d,
    output logic                flush_e,
    output logic                flush_m,
    output logic                flush_w,
    output logic                mc_busy,
    output logic                redir_pend
);
    ctrl_state_t     state_q;
    logic [XLEN-1:0] pc_q, tgt_q;
    logic            dwait, redir, mcb, lu;

    assign dwait = dmem_req & ~dmem_ok;
    assign redir = redirect_valid & ~dwait;
    assign lu    = mem_is_load & (mem_dst != 5'd0) &
                   ((ex_ra1 == mem_dst) | (ex_uses_rs2 & (ex_ra2 == mem_dst)));

    mc_timer #(.W(MC_LAT_W)) u_mc_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (mc_start),
        .lat    (mc_lat),
        .freeze (dwait),
        .clear  (redir),
        .busy   (mcb)
    );

    assign mc_busy    = mcb & ~reset;
    assign pc_o       = pc_q;
    assign redir_pend = (state_q == REDIR_WAIT);

    // First match wins; each branch leaves flush low on any stalled stage.
    always_comb begin
        {stall_f, stall_d, stall_e, stall_m} = 4'b0000;
        {flush_d, flush_e, flush_m, flush_w} = 4'b0000;
        if (reset) begin
            {flush_d, flush_e, flush_m, flush_w} = 4'b1111;
        end else if (dwait) begin
            {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
            flush_w = 1'b1;
        end else if (redir) begin
            {flush_d, flush_e, flush_m} = 3'b111;
        end else if (mcb | lu) begin
            {stall_f, stall_d, stall_e} = 3'b111;
            flush_m = 1'b1;
        end else if (~ifetch_ok | (state_q == REDIR_WAIT)) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC[XLEN-1:0];
            tgt_q   <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redir) begin
                        if (ifetch_ok) begin
                            pc_q <= redirect_pc;
                        end else begin
                            tgt_q   <= redirect_pc;
                            state_q <= REDIR_WAIT;
                        end
                    end else if (~stall_f) begin
                        pc_q <= pc_q + XLEN'(4);
                    end
                end
                REDIR_WAIT: begin
                    if (redir) begin
                        // A newer redirect supersedes the buffered target.
                        if (ifetch_ok) begin
                            pc_q    <= redirect_pc;
                            state_q <= RUN;
                        end else begin
                            tgt_q <= redirect_pc;
                        end
                    end else if (ifetch_ok & ~dwait) begin
                        pc_q    <= tgt_q;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, fetch, load-use, multi-cycle,
// redirect buffering, redirect under data wait, PC wrap and mid-op reset.
module tb_pipe_ctrl;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset, ifetch_ok, dmem_req, dmem_ok, redirect_valid;
    logic [63:0] redirect_pc;
    logic [4:0]  ex_ra1, ex_ra2, mem_dst;
    logic        ex_uses_rs2, mem_is_load, mc_start;
    logic [5:0]  mc_lat;
    logic [63:0] pc_o;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        mc_busy, redir_pend;
    logic [7:0]  ctl;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};

    pipe_ctrl #(.XLEN(64), .RESET_PC(RPC), .MC_LAT_W(6)) dut (
        .clk(clk), .reset(reset), .ifetch_ok(ifetch_ok), .dmem_req(dmem_req),
        .dmem_ok(dmem_ok), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ex_ra1(ex_ra1), .ex_ra2(ex_ra2), .ex_uses_rs2(ex_uses_rs2),
        .mem_is_load(mem_is_load), .mem_dst(mem_dst), .mc_start(mc_start),
        .mc_lat(mc_lat), .pc_o(pc_o), .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e),
        .flush_m(flush_m), .flush_w(flush_w), .mc_busy(mc_busy), .redir_pend(redir_pend)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifetch_ok = 1'b1; dmem_req = 1'b0; dmem_ok = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; ex_ra1 = '0; ex_ra2 = '0; ex_uses_rs2 = 1'b0;
        mem_is_load = 1'b0; mem_dst = '0; mc_start = 1'b0; mc_lat = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        #1;
        tests++; if (ctl !== 8'h0F) begin fails++; $display("FAIL reset_ctl got %h exp 0f", ctl); end
        step();
        tests++; if (pc_o !== RPC) begin fails++; $display("FAIL reset_pc got %h exp %h", pc_o, RPC); end
        tests++; if ({redir_pend, mc_busy} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {redir_pend, mc_busy}); end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (pc_o !== RPC + 64'(4 * i)) begin fails++; $display("FAIL fetch_pc%0d got %h exp %h", i, pc_o, RPC + 64'(4 * i)); end
            tests++; if (ctl !== 8'h00) begin fails++; $display("FAIL fetch_ctl%0d got %h exp 00", i, ctl); end
            step();
        end
    endtask

    task automatic test_load_use();
        logic [63:0] p;
        p = pc_o;
        mem_is_load = 1'b1; mem_dst = 5'd5; ex_ra2 = 5'd5; ex_ra1 = 5'd1; ex_uses_rs2 = 1'b1;
        #1;
        tests++; if (ctl !== 8'hE2) begin fails++; $display("FAIL lu_ctl got %h exp e2", ctl); end
        step();
        tests++; if (pc_o !== p) begin fails++; $display("FAIL lu_pc_hold got %h exp %h", pc_o, p); end
        ex_uses_rs2 = 1'b0;
        #1;
        tests++; if (ctl !== 8'h00) begin fails++; $display("FAIL lu_imm_ctl got %h exp 00", ctl); end
        ex_uses_rs2 = 1'b1; mem_dst = 5'd0; ex_ra1 = 5'd0; ex_ra2 = 5'd0;
        #1;
        tests++; if (ctl !== 8'h00) begin fails++; $display("FAIL lu_x0_ctl got %h exp 00", ctl); end
        step();
        tests++; if (pc_o !== p + 64'd4) begin fails++; $display("FAIL lu_pc_adv got %h exp %h", pc_o, p + 64'd4); end
        idle();
    endtask

    task automatic test_multicycle();
        int cnt;
        cnt = 0;
        mc_start = 1'b1; mc_lat = 6'd4;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (stall_e) cnt++;
            tests++; if (mc_busy !== (c < 3)) begin fails++; $display("FAIL mc_busy_c%0d got %b exp %b", c, mc_busy, c < 3); end
            step();
            mc_start = 1'b0;
        end
        tests++; if (cnt != 3) begin fails++; $display("FAIL mc_stall_cnt got %0d exp 3", cnt); end

        cnt = 0;
        mc_start = 1'b1; mc_lat = 6'd4;
        for (int c = 0; c < 8; c++) begin
            dmem_req = (c == 2 || c == 3);
            #1;
            if (stall_e) cnt++;
            step();
            mc_start = 1'b0;
        end
        dmem_req = 1'b0;
        tests++; if (cnt != 5) begin fails++; $display("FAIL mc_dwait_cnt got %0d exp 5", cnt); end

        mc_start = 1'b1; mc_lat = 6'd1;
        #1;
        tests++; if ({stall_e, mc_busy} !== 2'b00) begin fails++; $display("FAIL mc_lat1 got %b exp 00", {stall_e, mc_busy}); end
        step();
        idle();
    endtask

    task automatic test_redirect();
        logic [63:0] p;
        p = pc_o;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0100; ifetch_ok = 1'b0;
        #1;
        tests++; if (ctl !== 8'h0E) begin fails++; $display("FAIL redir_ctl got %h exp 0e", ctl); end
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ifetch_ok = (c == 2);
            #1;
            tests++; if (redir_pend !== 1'b1) begin fails++; $display("FAIL rw_pend%0d got %b exp 1", c, redir_pend); end
            tests++; if (pc_o !== p) begin fails++; $display("FAIL rw_pc%0d got %h exp %h", c, pc_o, p); end
            tests++; if (ctl !== 8'h88) begin fails++; $display("FAIL rw_ctl%0d got %h exp 88", c, ctl); end
            step();
        end
        tests++; if (pc_o !== 64'h8000_0100) begin fails++; $display("FAIL rw_newpc got %h exp 80000100", pc_o); end
        tests++; if (redir_pend !== 1'b0) begin fails++; $display("FAIL rw_exit got %b exp 0", redir_pend); end
        idle();
    endtask

    task automatic test_redir_dwait();
        logic [63:0] p;
        p = pc_o;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; dmem_req = 1'b1; dmem_ok = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++; if (ctl !== 8'hF1) begin fails++; $display("FAIL dw_ctl%0d got %h exp f1", c, ctl); end
            step();
            tests++; if ({pc_o, redir_pend} !== {p, 1'b0}) begin fails++; $display("FAIL dw_hold%0d got %h/%b exp %h/0", c, pc_o, redir_pend, p); end
        end
        dmem_ok = 1'b1;
        #1;
        tests++; if (ctl !== 8'h0E) begin fails++; $display("FAIL dw_accept_ctl got %h exp 0e", ctl); end
        step();
        tests++; if (pc_o !== 64'h8000_0200) begin fails++; $display("FAIL dw_accept_pc got %h exp 80000200", pc_o); end
        idle();
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        idle();
        tests++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin fails++; $display("FAIL wrap_pre got %h exp fffffffffffffffc", pc_o); end
        step();
        tests++; if (pc_o !== 64'h0) begin fails++; $display("FAIL wrap_post got %h exp 0", pc_o); end
    endtask

    task automatic test_reset_mid();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0300; ifetch_ok = 1'b0;
        step();
        redirect_valid = 1'b0; mc_start = 1'b1; mc_lat = 6'd5;
        step();
        mc_start = 1'b0;
        #1;
        tests++; if ({redir_pend, mc_busy} !== 2'b11) begin fails++; $display("FAIL mid_pre got %b exp 11", {redir_pend, mc_busy}); end
        reset = 1'b1;
        #1;
        tests++; if (ctl !== 8'h0F) begin fails++; $display("FAIL mid_rst_ctl got %h exp 0f", ctl); end
        step();
        reset = 1'b0; ifetch_ok = 1'b1;
        #1;
        tests++; if ({pc_o, redir_pend, mc_busy} !== {RPC, 2'b00}) begin fails++; $display("FAIL mid_post got %h/%b%b exp %h/00", pc_o, redir_pend, mc_busy, RPC); end
        step();
        tests++; if (pc_o !== RPC + 64'd4) begin fails++; $display("FAIL mid_next got %h exp %h", pc_o, RPC + 64'd4); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_load_use();
        test_multicycle();
        test_redirect();
        test_redir_dwait();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
